// File: rtl/palindrome_pkg.sv
// Shared definitions for the palindrome generator: FSM state encoding and default word width.
package palindrome_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EMIT = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/bit_reverse.sv
// Purely combinational bit-order reversal; supplies the mirrored lower half of each word.
module bit_reverse #(
   parameter int HALF = 4
) (
   input  logic [HALF-1:0] i_data,
   output logic [HALF-1:0] o_data
);

   for (genvar i = 0; i < HALF; i++) begin : g_rev
      assign o_data[i] = i_data[HALF-1-i];
   end

endmodule

// File: rtl/palindrome_generator.sv
// Emits bursts of palindromic words {h, reverse(h)} with a valid/ready handshake; h increments per transfer.
module palindrome_generator
   import palindrome_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH/2-1:0] seed,
   input  logic [WIDTH/2:0]   count,
   output logic [WIDTH-1:0]   data_out,
   output logic               valid,
   input  logic               ready,
   output logic               busy,
   output logic               done
);

   localparam int HALF = WIDTH / 2;

   state_t          r_state, w_state_nxt;
   logic [HALF-1:0] r_h, w_h_nxt, w_h_rev;
   logic [HALF:0]   r_remaining, w_remaining_nxt;
   logic            r_valid, r_busy, r_done;
   logic            w_xfer;

   assign w_xfer = r_valid && ready;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      w_state_nxt     = r_state;
      w_h_nxt         = r_h;
      w_remaining_nxt = r_remaining;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               if (count != '0) begin
                  w_state_nxt     = EMIT;
                  w_h_nxt         = seed;
                  w_remaining_nxt = count;
               end else begin
                  w_state_nxt = DONE;
               end
            end
         end
         EMIT: begin
            if (w_xfer) begin
               w_h_nxt         = r_h + HALF'(1);
               w_remaining_nxt = r_remaining - (HALF+1)'(1);
               if (r_remaining == (HALF+1)'(1)) w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Flags are registered from the next state so they change exactly with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_h         <= '0;
         r_remaining <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from pre-edge values.
         r_state     <= w_state_nxt;
         r_h         <= w_h_nxt;
         r_remaining <= w_remaining_nxt;
         r_valid     <= (w_state_nxt == EMIT);
         r_busy      <= (w_state_nxt != IDLE);
         r_done      <= (w_state_nxt == DONE);
      end
   end

   bit_reverse #(
      .HALF (HALF)
   ) u_bit_reverse (
      .i_data (r_h),
      .o_data (w_h_rev)
   );

   assign data_out = r_valid ? {r_h, w_h_rev} : '0;
   assign valid    = r_valid;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_palindrome_generator.sv
// Directed self-checking bench for palindrome_generator at WIDTH=8.
module tb_palindrome_generator;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] seed;
   logic [4:0] count;
   logic [7:0] data_out;
   logic       valid;
   logic       ready;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   palindrome_generator #(
      .WIDTH (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .seed     (seed),
      .count    (count),
      .data_out (data_out),
      .valid    (valid),
      .ready    (ready),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic is_pal(input logic [7:0] d);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) if (d[7-i] !== d[i]) ok = 1'b0;
      return ok;
   endfunction

   initial begin
      rst_n = 1'b0; start = 1'b0; seed = '0; count = '0; ready = 1'b0;
      #2;
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_data", data_out, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("idle_valid", valid, 0);

      // Basic burst: seed 1, three words
      start = 1; seed = 4'h1; count = 5'd3; ready = 1;
      tick(); start = 0;
      check("b1_w0", data_out, 8'h18);
      check("b1_v0", valid, 1);
      tick(); check("b1_w1", data_out, 8'h24);
      tick(); check("b1_w2", data_out, 8'h3C);
      tick();
      check("b1_valid_drop", valid, 0);
      check("b1_done", done, 1);
      check("b1_busy_done", busy, 1);
      check("b1_data_zero", data_out, 0);
      tick();
      check("b1_done_clear", done, 0);
      check("b1_busy_clear", busy, 0);

      // Wrap of the half register
      start = 1; seed = 4'hF; count = 5'd2;
      tick(); start = 0;
      check("b2_w0", data_out, 8'hFF);
      tick(); check("b2_w1_wrap", data_out, 8'h00);
      check("b2_w1_valid", valid, 1);
      tick(); check("b2_done", done, 1);
      tick(); check("b2_done_once", done, 0);

      // Backpressure: hold for four cycles
      ready = 0; start = 1; seed = 4'hA; count = 5'd1;
      tick(); start = 0;
      for (int i = 0; i < 4; i++) begin
         check("b3_hold_data", data_out, 8'hA5);
         check("b3_hold_valid", valid, 1);
         tick();
      end
      ready = 1;
      check("b3_xfer_data", data_out, 8'hA5);
      tick();
      check("b3_valid_after", valid, 0);
      check("b3_done", done, 1);
      tick();

      // Zero-length burst
      start = 1; count = 5'd0; seed = 4'h7;
      tick(); start = 0;
      check("b4_valid", valid, 0);
      check("b4_busy", busy, 1);
      check("b4_done", done, 1);
      tick();
      check("b4_busy_clear", busy, 0);
      check("b4_done_clear", done, 0);

      // Reset mid-burst
      start = 1; seed = 4'h5; count = 5'd4;
      tick(); start = 0;
      check("b5_w0", data_out, 8'h5A);
      tick();
      check("b5_w1", data_out, 8'h66);
      #2 rst_n = 0;
      #1;
      check("b5_rst_valid", valid, 0);
      check("b5_rst_busy", busy, 0);
      check("b5_rst_data", data_out, 0);
      start = 1; seed = 4'h9; count = 5'd1;
      tick();
      check("b5_start_in_rst", valid, 0);
      rst_n = 1; start = 0;
      tick();
      check("b5_no_done", done, 0);
      check("b5_idle_valid", valid, 0);
      start = 1; seed = 4'h3; count = 5'd1;
      tick(); start = 0;
      check("b5_fresh", data_out, 8'h3C);
      tick();
      check("b5_fresh_done", done, 1);
      tick();

      // start pulsed during EMIT is ignored
      start = 1; seed = 4'h2; count = 5'd3;
      tick();
      seed = 4'hC; count = 5'd1;
      check("b6_w0", data_out, 8'h24);
      check("b6_pal0", is_pal(data_out), 1);
      tick();
      check("b6_w1", data_out, 8'h3C);
      check("b6_pal1", is_pal(data_out), 1);
      tick();
      check("b6_w2", data_out, 8'h42);
      check("b6_pal2", is_pal(data_out), 1);
      start = 0;
      tick();
      check("b6_done", done, 1);
      check("b6_valid", valid, 0);
      tick();
      check("b6_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/palindrome_generator.md
PALINDROME_GENERATOR -- requirements
Module: palindrome_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, output word width; even, >= 2; HALF = WIDTH/2.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  burst request; sampled only in IDLE.
REQ-005 SHALL have port seed  input  HALF  upper half of first word; latched on accepted start.
REQ-006 SHALL have port count  input  HALF+1  words in burst; latched on accepted start.
REQ-007 SHALL have port data_out  output  WIDTH  generated palindrome word.
REQ-008 SHALL have port valid  output  1  data_out holds a word to transfer.
REQ-009 SHALL have port ready  input  1  downstream accepts data_out.
REQ-010 SHALL have port busy  output  1  high in EMIT and DONE.
REQ-011 SHALL have port done  output  1  one-cycle pulse ending every accepted burst.

Function
REQ-012 SHALL implement FSM states IDLE, EMIT, DONE.
REQ-013 IDLE: start=1, count!=0 -> latch seed into half register h, count into remaining, go EMIT.
REQ-014 IDLE: start=1, count==0 -> go DONE directly; no word emitted.
REQ-015 valid SHALL be 1 exactly in EMIT; first valid in the cycle after start is accepted (latency 1).
REQ-016 data_out SHALL equal {h, bit-reverse(h)}: data_out[WIDTH-1-i] == data_out[i] for all i.
REQ-017 Transfer occurs when valid && ready in the same cycle; valid SHALL NOT depend combinationally on ready.
REQ-018 While valid && !ready, data_out and valid SHALL hold stable.
REQ-019 Each transfer: h <= h+1 mod 2^HALF (all-ones wraps to zero); remaining <= remaining-1.
REQ-020 Transfer with remaining==1 -> DONE next cycle; valid drops that cycle.
REQ-021 DONE SHALL last one cycle with done=1, then IDLE unconditionally.
REQ-022 start SHALL be ignored in EMIT and DONE; seed/count changes there SHALL have no effect.
REQ-023 count > 2^HALF SHALL be honoured; h keeps wrapping, words repeat.
REQ-024 data_out SHALL be 0 whenever valid=0.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, valid=0, busy=0, done=0, data_out=0, h=0, remaining=0.
REQ-026 Reset mid-burst SHALL abandon the burst with no done pulse; first start after release begins a fresh burst.
REQ-027 start during the rst_n release cycle SHALL be accepted only if rst_n was high at that clock edge.

Structure
REQ-028 SHALL place state encoding (IDLE/EMIT/DONE) and default WIDTH in shared package palindrome_pkg.
REQ-029 SHALL use one sub-module, bit_reverse (parameter HALF, purely combinational), for the lower half.
REQ-030 SHALL be synthesizable; no latches; registered outputs except data_out mapping from h.

Verification (WIDTH=8)
REQ-031 start, seed=1, count=3, ready=1 -> data_out 0x18, 0x24, 0x3C on consecutive cycles; done next cycle.
REQ-032 start, seed=0xF, count=2, ready=1 -> 0xFF then 0x00 (wrap); done once.
REQ-033 seed=0xA, count=1, ready low 4 cycles then high -> 0xA5 held stable 5 cycles; single transfer; done.
REQ-034 start, count=0 -> no valid; busy=1 and done=1 for one cycle, then IDLE.
REQ-035 rst_n low during 2nd of 4 words -> valid/busy 0 immediately, no done; new start seed=3,count=1 -> 0x3C.
REQ-036 start pulsed during EMIT with different seed -> ignored; every transferred word passes palindrome check.
